// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM state encodings
// and the width helper used to size select, pointer and burst counters.
package mux_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Bits needed to hold values 0..n-1, never less than one bit so that
    // a 2-way arbiter still gets a real select line.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Bus bundle between the producers and the shared output path. The arbiter
// takes the slave side; whoever drives requests and data takes the master.
interface mux_rr_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = clog2(N);

    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   grant;
    logic [SW-1:0]  sel;
    logic [W-1:0]   data_out;
    logic           valid_out;

    modport slave (
        input  req,
        input  data_in,
        output grant,
        output sel,
        output data_out,
        output valid_out
    );

    modport master (
        output req,
        output data_in,
        input  grant,
        input  sel,
        input  data_out,
        input  valid_out
    );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request
// found when searching upward from base, wrapping around modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] base,
    output logic          found,
    output logic [SW-1:0] idx
);

    logic [SW:0] cand;

    // Walk the candidates from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, base} + (SW + 1)'(k);
            if (cand >= (SW + 1)'(N)) begin
                cand = cand - (SW + 1)'(N);
            end
            if (req[cand[SW-1:0]]) begin
                found = 1'b1;
                idx   = cand[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared N:1 word mux, with
// bounded burst length per owner and a registered output word + valid.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_arbiter_if.slave   bus
);

    localparam int SW = clog2(N);
    localparam int BW = clog2(MAX_BURST + 1);

    logic [0:0]    state;
    logic [SW-1:0] ptr;
    logic [BW-1:0] burst_cnt;

    logic          owner_req;
    logic          beat;
    logic          last_beat;
    logic          rearb;
    logic          found;
    logic [SW-1:0] pick_idx;

    // The owner is released either by dropping its request or by spending
    // its last allowed beat; in both cases a successor is picked this cycle
    // so ownership hands over without a dead cycle. Starting the search at
    // ptr (one past the owner) puts the current owner last in line.
    assign owner_req = bus.req[bus.sel];
    assign beat      = (state == ST_GRANT) && owner_req;
    assign last_beat = beat && (burst_cnt == BW'(MAX_BURST - 1));
    assign rearb     = (state == ST_IDLE) || (state == ST_GRANT && (!owner_req || last_beat));

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req   (bus.req),
        .base  (ptr),
        .found (found),
        .idx   (pick_idx)
    );

    // Ownership FSM: grant/sel are registered so the mux select only moves on clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            burst_cnt <= '0;
            bus.grant <= '0;
            bus.sel   <= '0;
        end else if (rearb) begin
            burst_cnt <= '0;
            if (found) begin
                state     <= ST_GRANT;
                bus.sel   <= pick_idx;
                bus.grant <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                ptr       <= (pick_idx == SW'(N - 1)) ? '0 : pick_idx + SW'(1);
            end else begin
                state     <= ST_IDLE;
                bus.grant <= '0;
            end
        end else if (beat) begin
            burst_cnt <= burst_cnt + BW'(1);
        end
    end

    // Output register: capture the owner's word on a beat, otherwise hold it and drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
        end else begin
            bus.valid_out <= beat;
            if (beat) begin
                bus.data_out <= bus.data_in[bus.sel*W +: W];
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter with N=4, W=8, MAX_BURST=4:
// a table of cycle-by-cycle vectors plus hand-written multi-cycle sequences.
module tb_mux_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  grant;
        logic [1:0]  sel;
        logic        valid;
        logic [7:0]  dout;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   beats;
    vec_t vecs[$];

    mux_rr_arbiter_if #(.N(N), .W(W)) bus ();

    mux_rr_arbiter #(
        .N         (N),
        .W         (W),
        .MAX_BURST (MB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [31:0] data);
        bus.req     = req;
        bus.data_in = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] grant, input logic [1:0] sel,
                               input logic valid, input logic [7:0] dout);
        checkVal({name, ".grant"}, int'(bus.grant), int'(grant));
        if (grant != 4'b0000) begin
            checkVal({name, ".sel"}, int'(bus.sel), int'(sel));
        end
        checkVal({name, ".valid"}, int'(bus.valid_out), int'(valid));
        checkVal({name, ".data"}, int'(bus.data_out), int'(dout));
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus(4'b0000, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Stimulus and checking sequence.
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(4'b1111, 32'h0);

        // Reset held with all requests high, then released.
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_hold", 4'b0000, 2'd0, 1'b0, 8'h00);
        checkVal("reset_hold.sel", int'(bus.sel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("reset_release", 4'b0001, 2'd0, 1'b0, 8'h00);

        // Round-robin with every requester busy, then a single requester.
        vecs.push_back('{4'b1111, 32'h13121110, 4'b0001, 2'd0, 1'b0, 8'h00});
        for (int i = 0; i < 3; i++) vecs.push_back('{4'b1111, 32'h13121110, 4'b0001, 2'd0, 1'b1, 8'h10});
        vecs.push_back('{4'b1111, 32'h13121110, 4'b0010, 2'd1, 1'b1, 8'h10});
        for (int i = 0; i < 3; i++) vecs.push_back('{4'b1111, 32'h13121110, 4'b0010, 2'd1, 1'b1, 8'h11});
        vecs.push_back('{4'b1111, 32'h13121110, 4'b0100, 2'd2, 1'b1, 8'h11});
        for (int i = 0; i < 3; i++) vecs.push_back('{4'b1111, 32'h13121110, 4'b0100, 2'd2, 1'b1, 8'h12});
        vecs.push_back('{4'b1111, 32'h13121110, 4'b1000, 2'd3, 1'b1, 8'h12});
        for (int i = 0; i < 3; i++) vecs.push_back('{4'b1111, 32'h13121110, 4'b1000, 2'd3, 1'b1, 8'h13});
        vecs.push_back('{4'b1111, 32'h13121110, 4'b0001, 2'd0, 1'b1, 8'h13});
        vecs.push_back('{4'b0000, 32'h13121110, 4'b0000, 2'd0, 1'b0, 8'h13});
        vecs.push_back('{4'b0100, 32'h00A50000, 4'b0100, 2'd2, 1'b0, 8'h13});
        for (int i = 0; i < 3; i++) vecs.push_back('{4'b0100, 32'h00A50000, 4'b0100, 2'd2, 1'b1, 8'hA5});
        vecs.push_back('{4'b0000, 32'h00A50000, 4'b0000, 2'd2, 1'b0, 8'hA5});

        resetDut();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req, vecs[i].data);
            step();
            checkOutput($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].valid, vecs[i].dout);
        end

        // Sole requester keeps being re-granted across burst limits.
        resetDut();
        applyStimulus(4'b0010, 32'h00005A00);
        step();
        checkOutput("sole_first", 4'b0010, 2'd1, 1'b0, 8'h00);
        beats = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            checkVal($sformatf("sole_grant%0d", i), int'(bus.grant), 4'b0010);
            if (bus.valid_out) beats++;
        end
        checkVal("sole_beats", beats, 10);
        checkVal("sole_data", int'(bus.data_out), 8'h5A);

        // Owner drops while another requester rises in the same cycle.
        resetDut();
        applyStimulus(4'b0001, 32'hD0C0B0A0);
        step();
        checkOutput("drop_grant0", 4'b0001, 2'd0, 1'b0, 8'h00);
        step();
        checkOutput("drop_beat0", 4'b0001, 2'd0, 1'b1, 8'hA0);
        applyStimulus(4'b1000, 32'hD0C0B0A0);
        step();
        checkOutput("drop_handoff", 4'b1000, 2'd3, 1'b0, 8'hA0);
        step();
        checkOutput("drop_beat3", 4'b1000, 2'd3, 1'b1, 8'hD0);

        // Asynchronous reset in the middle of a burst, then ptr back at 0.
        resetDut();
        applyStimulus(4'b0100, 32'h00C30000);
        step();
        checkOutput("async_grant", 4'b0100, 2'd2, 1'b0, 8'h00);
        step();
        checkOutput("async_beat", 4'b0100, 2'd2, 1'b1, 8'hC3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'b0000, 2'd0, 1'b0, 8'h00);
        checkVal("async_reset.sel", int'(bus.sel), 0);
        applyStimulus(4'b1111, 32'h00C30000);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("async_ptr", 4'b0001, 2'd0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for a shared N:1 data multiplexer. It accepts per-requester request lines, grants exactly one requester at a time with bounded burst length, and drives the select of the N:1 word mux. It registers the selected word with a valid flag for the downstream consumer. It sits between independent producers and a single shared output path, replacing hand-wired select logic.

## Interface
- N, default 4: number of requesters (2..16).
- W, default 8: data word width.
- MAX_BURST, default 8: maximum consecutive granted beats per owner (1..255).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  request per requester; held high while it has words to send.
- data_in  in  N*W  packed words; requester i on bits [i*W +: W].
- grant  out  N  one-hot grant; all-zero when idle.
- sel  out  clog2(N)  binary index of current owner; drives the mux select.
- data_out  out  W  registered muxed word.
- valid_out  out  1  data_out carries a beat.

## Operation
- The FSM has two states.
  - IDLE: grant = 0.
  - GRANT: exactly one grant bit set; sel equals its index.
- Arbitration picks the first set req bit searching upward from ptr, wrapping modulo N.
  - ptr resets to 0.
  - On every new grant to index i, ptr becomes (i+1) mod N.
- IDLE → GRANT: any req high; the winner is chosen in the same cycle and granted at the next edge.
- Beat: a cycle in GRANT where req[sel] = 1. Each beat increments burst_cnt, which is cleared on every new grant.
- Release occurs in a GRANT cycle in either of two cases:
  - req[sel] = 0. No beat occurs that cycle.
  - The beat is the MAX_BURST-th of the current grant.
- On release, rearbitration happens in the same cycle using the current req:
  - In the drop case, the owner is naturally excluded.
  - In the burst-limit case, the search starts at ptr, so the owner is chosen last. The owner is re-granted only if it is the sole requester, with a fresh burst.
  - If no requester wins, go to IDLE.
- There is no dead cycle between owners when others are waiting.
- Datapath: at each edge, data_out ← data_in[sel*W +: W] and valid_out ← 1 if the cycle was a beat. Otherwise valid_out ← 0 and data_out holds.
- A req that rises and falls while not granted is ignored; there is no request latching.
- Word widths do not change; there is no arithmetic on data.

## Timing
- Reset is asynchronous. Reset values:
  - state IDLE, ptr 0, burst_cnt 0.
  - grant 0, sel 0.
  - data_out 0, valid_out 0.
- Reset asserted mid-burst clears everything immediately. The in-flight beat is lost.
- Grant latency: req sampled high at edge t in IDLE → grant visible after edge t+1 (1 cycle).
- Data latency: beat in cycle k → data_out/valid_out valid after the edge ending cycle k (1 cycle).
- A fully busy N-way system yields 100% output utilisation. Each owner gets at most MAX_BURST consecutive beats.
- With N requesters continuously active, worst-case wait from req to grant is (N-1)·MAX_BURST cycles + 1.
- Simultaneous drop by the owner and rise by another requester: the new requester is granted at the next edge.
- sel and grant change only at clock edges and are glitch-free to the mux.

## Structure
- Shared package mux_arb_pkg holds:
  - state encodings (ST_IDLE = 1'b0, ST_GRANT = 1'b1).
  - the clog2 helper function used for sel and ptr width.
- One sub-module: rr_pick, a combinational rotating-priority picker.
  - Inputs: req[N], base[clog2(N)].
  - Outputs: found, idx.
  - It is instantiated once in mux_rr_arbiter.
- FSM, ptr, burst_cnt and data registers live in mux_rr_arbiter.
- Target is roughly 200 lines including rr_pick.

## Test plan
All scenarios use N=4, W=8, MAX_BURST=4.
- Reset: hold rst_n=0 with req=4'b1111 → grant=0, sel=0, valid_out=0. Release rst_n → grant=0001 after one edge.
- Single requester: req=0100 for 3 cycles, data_in[2]=8'hA5 → grant=0100 one cycle later. Three valid beats of A5 follow, then grant=0 one edge after req drops.
- Round-robin: req=1111 held, each data_in[i]=8'h10+i → grant sequence 0001, 0010, 0100, 1000, 0001. Each owner holds 4 cycles with no gaps; valid_out stays high continuously.
- Sole requester at burst limit: req=0010 held for 10 cycles → continuous grant=0010. burst_cnt wraps every 4 beats; there are 10 valid beats.
- Drop with handoff: owner 0 drops req while req[3]=1 rises the same cycle → grant=1000 at the next edge. No valid_out gap beyond the single drop cycle.
- Async reset mid-burst: assert rst_n=0 between edges during grant=0100 → grant, sel, valid_out go to 0 immediately, before the next edge. ptr returns to 0.
